rf_write_arbiter: RTL and testbench

Shares the single write port of the 32x32 register file among `NREQ` writeback requesters (ALU writeback, load writeback, multi-cycle units) using round-robin arbitration. It sits between the execution units and the register file write port, drives `RegWrite`/`rc`/`dc` from a registered staging slot, and exposes forwarding hits so the read ports can bypass a write that is staged but not yet committed.

---
 rtl/rf_write_arbiter_pkg.sv | 16 +
 rtl/rr_pick.sv | 27 ++
 rtl/rf_write_arbiter.sv | 95 +++++++++
 tb/tb_rf_write_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared register-file constants for the writeback path.
// Used by the write arbiter and the register file.
package rf_write_arbiter_pkg;

  localparam int RF_AW       = 5;
  localparam int RF_DW       = 32;
  localparam int RF_ZERO_IDX = 0;

  function automatic int wrap_inc(
    input int v,
    input int n
  );
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches req_i from ptr_i upward with wrap; first set bit wins.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] win_o,
  output logic          any_o
);

  always_comb begin
    gnt_o = '0;
    win_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_o && req_i[(int'(ptr_i) + k) % N]) begin
        any_o = 1'b1;
        gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
        win_o = PW'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register-file write port.
// Stages one write per cycle and exposes forwarding hits.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] req_rc,
  input  logic [NREQ*DW-1:0] req_dc,
  output logic [NREQ-1:0]  gnt,
  input  logic             wr_hold,
  output logic             RegWrite,
  output logic [AW-1:0]    rc,
  output logic [DW-1:0]    dc,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic [DW-1:0]    fwd_data
);

  localparam int PW = $clog2(NREQ);
  localparam logic [AW-1:0] ZIDX =
    AW'(RF_ZERO_IDX);

  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   win;
  logic            any;
  logic            fire;
  logic [AW-1:0]   rc_sel;
  logic [DW-1:0]   dc_sel;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            we_q, we_d;
  logic [AW-1:0]   rc_q, rc_d;
  logic [DW-1:0]   dc_q, dc_d;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .win_o (win),
    .any_o (any)
  );

  assign fire   = any && !wr_hold;
  assign rc_sel = req_rc[int'(win)*AW +: AW];
  assign dc_sel = req_dc[int'(win)*DW +: DW];
  assign gnt    = (rst_n && fire) ? pick_gnt : '0;

  always_comb begin
    ptr_d = ptr_q;
    we_d  = 1'b0;
    rc_d  = rc_q;
    dc_d  = dc_q;
    if (fire) begin
      ptr_d = PW'(wrap_inc(int'(win), NREQ));
      rc_d  = rc_sel;
      dc_d  = dc_sel;
      we_d  = (rc_sel != ZIDX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      we_q  <= 1'b0;
      rc_q  <= '0;
      dc_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      we_q  <= we_d;
      rc_q  <= rc_d;
      dc_q  <= dc_d;
    end
  end

  assign RegWrite = we_q;
  assign rc       = rc_q;
  assign dc       = dc_q;
  assign fwd_data = dc_q;

  // Index 0 never forwards: it reads as zero.
  assign fwd_a = we_q && (rc_q == ra) && (ra != ZIDX);
  assign fwd_b = we_q && (rc_q == rb) && (rb != ZIDX);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter.
// Compares against a round-robin model plus a register-file model.
module tb_rf_write_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_rc;
  logic [N*DW-1:0] req_dc;
  logic [N-1:0]    gnt;
  logic            wr_hold;
  logic            RegWrite;
  logic [AW-1:0]   rc;
  logic [DW-1:0]   dc;
  logic [AW-1:0]   ra;
  logic [AW-1:0]   rb;
  logic            fwd_a;
  logic            fwd_b;
  logic [DW-1:0]   fwd_data;

  int vectors;
  int errors;

  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_rc;
  logic [DW-1:0] m_dc;
  logic [DW-1:0] m_rf [32] = '{default: '0};
  logic [DW-1:0] rf   [32] = '{default: '0};

  rf_write_arbiter #(
    .NREQ (N),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_rc   (req_rc),
    .req_dc   (req_dc),
    .gnt      (gnt),
    .wr_hold  (wr_hold),
    .RegWrite (RegWrite),
    .rc       (rc),
    .dc       (dc),
    .ra       (ra),
    .rb       (rb),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b),
    .fwd_data (fwd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream register file fed by the DUT write port.
  always @(posedge clk) begin
    if (rst_n && RegWrite && rc != 0)
      rf[rc] <= dc;
  end

  function automatic int pick(
    input logic [N-1:0] r,
    input int p
  );
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    int w;
    w = pick(req, m_ptr);
    if (!rst_n || wr_hold || w < 0) return '0;
    return N'(1) << w;
  endfunction

  function automatic logic exp_fwd(
    input logic [AW-1:0] idx
  );
    return m_we && (m_rc == idx) && (idx != 0);
  endfunction

  task automatic set_f(
    input int i,
    input logic [AW-1:0] r,
    input logic [DW-1:0] d
  );
    req_rc[i*AW +: AW] = r;
    req_dc[i*DW +: DW] = d;
  endtask

  task automatic model_edge();
    int w;
    if (!rst_n) begin
      m_ptr = 0; m_we = 0;
      m_rc = '0; m_dc = '0;
      return;
    end
    if (m_we && m_rc != 0) m_rf[m_rc] = m_dc;
    w = pick(req, m_ptr);
    if (wr_hold || w < 0) begin
      m_we = 1'b0;
    end else begin
      m_rc  = req_rc[w*AW +: AW];
      m_dc  = req_dc[w*DW +: DW];
      m_we  = (m_rc != 0);
      m_ptr = (w + 1) % N;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_hold = 1'b0;
    req = '1; req_rc = '1; req_dc = '1;
    ra = '0; rb = '0;
    m_ptr = 0; m_we = 0; m_rc = '0; m_dc = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (gnt !== '0 || RegWrite !== 1'b0 ||
        rc !== '0 || dc !== '0) begin
      errors++;
      $display("FAIL reset: gnt=%b we=%b rc=%0d dc=%h req 0/0/0/0",
               gnt, RegWrite, rc, dc);
    end
    req = '0;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_rr_all();
    logic [N-1:0] e;
    for (int i = 0; i < N; i++)
      set_f(i, AW'(i + 1), $urandom);
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      e = 3'b001 << (k % 3);
      vectors++;
      if (gnt !== e) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: got %b req %b", k, gnt, e);
      end
      tick();
      vectors++;
      if (RegWrite !== 1'b1 || rc !== AW'(k % 3 + 1) ||
          dc !== m_dc) begin
        errors++;
        $display("FAIL rr_slot[%0d]: we=%b rc=%0d dc=%h req 1/%0d/%h",
                 k, RegWrite, rc, dc, k % 3 + 1, m_dc);
      end
    end
    req = '0;
  endtask

  task automatic test_zero_idx();
    set_f(2, '0, 32'hCAFE_0000);
    req = 3'b100;
    #1;
    vectors++;
    if (gnt !== 3'b100) begin
      errors++;
      $display("FAIL zero_gnt: got %b req 100", gnt);
    end
    tick();
    vectors++;
    if (RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL zero_we: got %b req 0", RegWrite);
    end
    req = '0;
  endtask

  task automatic test_hold();
    set_f(0, 5'd4, 32'h0000_0044);
    set_f(1, 5'd6, 32'h0000_0066);
    req = 3'b011;
    wr_hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++;
      if (gnt !== '0) begin
        errors++;
        $display("FAIL hold_gnt[%0d]: got %b req 000", k, gnt);
      end
      tick();
      vectors++;
      if (RegWrite !== 1'b0) begin
        errors++;
        $display("FAIL hold_we[%0d]: got %b req 0", k, RegWrite);
      end
    end
    wr_hold = 1'b0;
    #1;
    vectors++;
    if (gnt !== 3'b001) begin
      errors++;
      $display("FAIL hold_release: got %b req 001", gnt);
    end
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_forward();
    set_f(1, 5'd7, 32'hDEAD_BEEF);
    req = 3'b010;
    #1;
    tick();
    req = '0;
    ra = 5'd7; rb = 5'd0;
    #1;
    vectors++;
    if (fwd_a !== 1'b1 || fwd_b !== 1'b0 ||
        fwd_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL fwd: a=%b b=%b d=%h req 1/0/deadbeef",
               fwd_a, fwd_b, fwd_data);
    end
    vectors++;
    if (rf[7] !== 32'h0) begin
      errors++;
      $display("FAIL fwd_old: rf7=%h req 0", rf[7]);
    end
    rb = 5'd7;
    #1;
    vectors++;
    if (fwd_b !== 1'b1) begin
      errors++;
      $display("FAIL fwd_b7: got %b req 1", fwd_b);
    end
    tick();
    vectors++;
    if (rf[7] !== 32'hDEAD_BEEF || fwd_a !== 1'b0) begin
      errors++;
      $display("FAIL fwd_commit: rf7=%h a=%b req deadbeef/0",
               rf[7], fwd_a);
    end
    ra = '0; rb = '0;
  endtask

  task automatic test_back_to_back();
    set_f(0, 5'd5, 32'h11);
    req = 3'b001;
    #1;
    tick();
    vectors++;
    if (RegWrite !== 1'b1 || dc !== 32'h11) begin
      errors++;
      $display("FAIL b2b_first: we=%b dc=%h req 1/11", RegWrite, dc);
    end
    set_f(1, 5'd5, 32'h22);
    req = 3'b010;
    #1;
    vectors++;
    if (gnt !== 3'b010) begin
      errors++;
      $display("FAIL b2b_gnt: got %b req 010", gnt);
    end
    tick();
    vectors++;
    if (RegWrite !== 1'b1 || dc !== 32'h22) begin
      errors++;
      $display("FAIL b2b_second: we=%b dc=%h req 1/22", RegWrite, dc);
    end
    req = '0;
    tick();
    vectors++;
    if (rf[5] !== 32'h22 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rf5: rf5=%h we=%b req 22/0", rf[5], RegWrite);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] old9;
    old9 = rf[9];
    set_f(1, 5'd9, old9 ^ 32'h5A5A_5A5A);
    req = 3'b010;
    #1;
    tick();
    req = '0;
    vectors++;
    if (RegWrite !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre: we=%b req 1", RegWrite);
    end
    #2;
    rst_n = 1'b0;
    m_ptr = 0; m_we = 0; m_rc = '0; m_dc = '0;
    #1;
    vectors++;
    if (RegWrite !== 1'b0 || rc !== '0 || dc !== '0) begin
      errors++;
      $display("FAIL rmid_clear: we=%b rc=%0d dc=%h req 0/0/0",
               RegWrite, rc, dc);
    end
    tick();
    rst_n = 1'b1;
    vectors++;
    if (rf[9] !== old9) begin
      errors++;
      $display("FAIL rmid_nowrite: rf9=%h req %h", rf[9], old9);
    end
    req = 3'b111;
    #1;
    vectors++;
    if (gnt !== 3'b001) begin
      errors++;
      $display("FAIL rmid_ptr: got %b req 001", gnt);
    end
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] e;
    for (int i = 0; i < 32; i++) m_rf[i] = rf[i];
    for (int c = 0; c < 300; c++) begin
      req = N'($urandom);
      wr_hold = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++)
        set_f(i, ($urandom_range(0, 5) == 0) ? '0 :
              AW'($urandom), $urandom);
      ra = ($urandom_range(0, 1) == 0) ? m_rc : AW'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      #1;
      e = exp_gnt();
      vectors++;
      if (gnt !== e || fwd_a !== exp_fwd(ra) ||
          fwd_b !== exp_fwd(rb) || fwd_data !== m_dc) begin
        errors++;
        $display("FAIL rnd_comb[%0d]: g=%b a=%b b=%b req %b/%b/%b",
                 c, gnt, fwd_a, fwd_b, e, exp_fwd(ra), exp_fwd(rb));
      end
      tick();
      vectors++;
      if (RegWrite !== m_we || rc !== m_rc || dc !== m_dc) begin
        errors++;
        $display("FAIL rnd_slot[%0d]: we=%b rc=%0d dc=%h req %b/%0d/%h",
                 c, RegWrite, rc, dc, m_we, m_rc, m_dc);
      end
    end
    req = '0; wr_hold = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (rf[i] !== m_rf[i]) begin
        errors++;
        $display("FAIL rnd_rf[%0d]: got %h req %h", i, rf[i], m_rf[i]);
      end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_rr_all();
    test_zero_idx();
    test_hold();
    test_forward();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
